// File: rtl/reg_dump_formatter.sv
// Snapshots the register file and streams it as ASCII lines "rN=HHHH\r\n" on a valid/ready byte port.
// Optional build macro REG_DUMP_PERIODIC_EN adds an idle-time auto-trigger every PERIOD_CYCLES clocks.
module reg_dump_formatter #(
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned PERIOD_CYCLES = 27_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0][15:0] regs,
  input  logic             start,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  if (NUM_REGS < 1 || NUM_REGS > 8 || PERIOD_CYCLES < 1) begin : g_param_check
    $error("reg_dump_formatter: NUM_REGS must be 1..8 and PERIOD_CYCLES at least 1");
  end

  localparam logic [2:0] LastReg  = 3'(NUM_REGS - 1);
  localparam logic [3:0] LastChar = 4'd8;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [7:0][15:0] snap_q, snap_d;
  logic [2:0]       reg_idx_q, reg_idx_d;
  logic [3:0]       char_idx_q, char_idx_d;
  logic             done_q, done_d;
  logic             trigger;
  logic [15:0]      cur_reg;
  logic [7:0]       cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    // 'A' - 10 = 8'h37
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

`ifdef REG_DUMP_PERIODIC_EN
  logic [31:0] period_cnt_q, period_cnt_d;
  logic        timer_hit;

  assign timer_hit = (state_q == StIdle) && (period_cnt_q == 32'(PERIOD_CYCLES - 1));
  assign trigger   = start || timer_hit;

  // Counts only while idle; cleared by any accepted trigger so it sits at zero during a dump.
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (state_q == StIdle) begin
      period_cnt_d = trigger ? 32'd0 : period_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q <= 32'd0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end
`else
  assign trigger = start;
`endif

  assign cur_reg = snap_q[reg_idx_q];

  always_comb begin
    cur_byte = 8'h00;
    case (char_idx_q)
      4'd0:    cur_byte = 8'h72;
      4'd1:    cur_byte = 8'h30 + {5'd0, reg_idx_q};
      4'd2:    cur_byte = 8'h3D;
      4'd3:    cur_byte = hex_ascii(cur_reg[15:12]);
      4'd4:    cur_byte = hex_ascii(cur_reg[11:8]);
      4'd5:    cur_byte = hex_ascii(cur_reg[7:4]);
      4'd6:    cur_byte = hex_ascii(cur_reg[3:0]);
      4'd7:    cur_byte = 8'h0D;
      4'd8:    cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    reg_idx_d  = reg_idx_q;
    char_idx_d = char_idx_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d    = StEmit;
          reg_idx_d  = 3'd0;
          char_idx_d = 4'd0;
          for (int unsigned i = 0; i < 8; i++) begin
            snap_d[i] = (i < NUM_REGS) ? regs[i] : 16'h0000;
          end
        end
      end
      StEmit: begin
        // out_valid is always high here, so out_ready alone marks a transfer
        if (out_ready) begin
          if (char_idx_q == LastChar) begin
            char_idx_d = 4'd0;
            if (reg_idx_q == LastReg) begin
              state_d   = StIdle;
              reg_idx_d = 3'd0;
              done_d    = 1'b1;
            end else begin
              reg_idx_d = reg_idx_q + 3'd1;
            end
          end else begin
            char_idx_d = char_idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      snap_q     <= '0;
      reg_idx_q  <= 3'd0;
      char_idx_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      reg_idx_q  <= reg_idx_d;
      char_idx_q <= char_idx_d;
      done_q     <= done_d;
    end
  end

  assign out_valid = (state_q == StEmit);
  assign busy      = (state_q == StEmit);
  assign out_data  = out_valid ? cur_byte : 8'h00;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_formatter.sv
// Scoreboard bench for reg_dump_formatter: expected bytes are queued at trigger time and
// popped by a negedge monitor on every transfer. Define REG_DUMP_PERIODIC_EN to run the timer test.
module tb_reg_dump_formatter;

  localparam int unsigned NumRegs = 8;
`ifdef REG_DUMP_PERIODIC_EN
  localparam int unsigned PeriodCycles = 100;
`else
  localparam int unsigned PeriodCycles = 27_000_000;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0][15:0] regs;
  logic             start;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  reg_dump_formatter #(
    .NUM_REGS      (NumRegs),
    .PERIOD_CYCLES (PeriodCycles)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .regs      (regs),
    .start     (start),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         cyc_cnt = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  int         rise_cyc = -1;
  int         done_cyc = -1;
  int         last_xfer_cyc = -1;
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_byte;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: samples mid-cycle; a transfer seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid === 1'b1 && !prev_valid) rise_cyc = cyc_cnt;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        xfer_cnt++;
        last_xfer_cyc = cyc_cnt;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h, required no transfer", out_data);
        end else begin
          exp_byte = exp_q.pop_front();
          if (out_data !== exp_byte) begin
            errors++;
            $display("FAIL byte_%0d: got %h, required %h", xfer_cnt, out_data, exp_byte);
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_data  = out_data;
      prev_valid = (out_valid === 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [7:0][15:0] v);
    string hx = "0123456789ABCDEF";
    for (int i = 0; i < int'(NumRegs); i++) begin
      exp_q.push_back(8'h72);
      exp_q.push_back(8'h30 + 8'(i));
      exp_q.push_back(8'h3D);
      for (int k = 3; k >= 0; k--) exp_q.push_back(hx[v[i][k*4 +: 4]]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base_d, input int budget, input bit rand_ready);
    int n = 0;
    while (done_cnt == base_d && n < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    out_ready = 1'b1;
  endtask

  task automatic set_default_regs();
    regs[0] = 16'hBEEF; regs[1] = 16'h0123; regs[2] = 16'h4567; regs[3] = 16'h89AB;
    regs[4] = 16'hCDEF; regs[5] = 16'hF00D; regs[6] = 16'h1A2B; regs[7] = 16'h9C3D;
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    set_default_regs();
    repeat (3) step();
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, required 00", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    rst_n = 1'b1;
`ifndef REG_DUMP_PERIODIC_EN
    repeat (100) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL idle_quiet: activity seen, required none for 100 cycles"); end
`endif
  endtask

  task automatic test_single_dump();
    int base_x = xfer_cnt;
    int base_d = done_cnt;
    int s;
    set_default_regs();
    out_ready = 1'b1;
    push_dump(regs);
    s = cyc_cnt;
    pulse_start();
    wait_done(base_d, 200, 1'b0);
    repeat (3) step();
    checks++; if (rise_cyc != s + 1) begin errors++; $display("FAIL first_latency: got %0d, required %0d", rise_cyc - s, 1); end
    checks++; if (xfer_cnt - base_x != 72) begin errors++; $display("FAIL dump_len: got %0d, required 72", xfer_cnt - base_x); end
    checks++; if (last_xfer_cyc - rise_cyc != 71) begin errors++; $display("FAIL back_to_back: span %0d, required 71", last_xfer_cyc - rise_cyc); end
    checks++; if (done_cyc != last_xfer_cyc + 1) begin errors++; $display("FAIL done_timing: got %0d, required %0d", done_cyc, last_xfer_cyc + 1); end
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL done_count: got %0d, required 1", done_cnt - base_d); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_empty: %0d left, required 0", exp_q.size()); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_after: busy=%b valid=%b, required 0 0", busy, out_valid); end
  endtask

  task automatic test_random_ready();
    int base_x = xfer_cnt;
    int base_d = done_cnt;
    set_default_regs();
    regs[7] = 16'h0A05;
    push_dump(regs);
    pulse_start();
    wait_done(base_d, 2000, 1'b1);
    repeat (3) step();
    checks++; if (xfer_cnt - base_x != 72) begin errors++; $display("FAIL rand_len: got %0d, required 72", xfer_cnt - base_x); end
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL rand_done: got %0d, required 1", done_cnt - base_d); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_sb: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_snapshot();
    int base_x = xfer_cnt;
    int base_d = done_cnt;
    set_default_regs();
    regs[3] = 16'h7E57;
    push_dump(regs);
    pulse_start();
    regs = {8{16'hFFFF}};
    repeat (30) step();
    pulse_start();
    wait_done(base_d, 200, 1'b0);
    repeat (20) step();
    checks++; if (xfer_cnt - base_x != 72) begin errors++; $display("FAIL snap_len: got %0d, required 72", xfer_cnt - base_x); end
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL snap_done: got %0d, required 1", done_cnt - base_d); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_ignored: valid=%b, required 0", out_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL snap_sb: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_dump();
    int base_x = xfer_cnt;
    int base_d = done_cnt;
    int n = 0;
    set_default_regs();
    push_dump(regs);
    pulse_start();
    while (xfer_cnt - base_x < 20 && n < 200) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_outputs: valid=%b busy=%b, required 0 0", out_valid, busy); end
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    checks++; if (xfer_cnt - base_x != 20) begin errors++; $display("FAIL abort_bytes: got %0d, required 20", xfer_cnt - base_x); end
    checks++; if (done_cnt != base_d) begin errors++; $display("FAIL abort_done: got %0d pulses, required 0", done_cnt - base_d); end
    base_x = xfer_cnt;
    push_dump(regs);
    pulse_start();
    wait_done(base_d, 200, 1'b0);
    repeat (2) step();
    checks++; if (xfer_cnt - base_x != 72) begin errors++; $display("FAIL redump_len: got %0d, required 72", xfer_cnt - base_x); end
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL redump_done: got %0d, required 1", done_cnt - base_d); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redump_sb: %0d left, required 0", exp_q.size()); end
  endtask

`ifdef REG_DUMP_PERIODIC_EN
  task automatic test_periodic();
    int r;
    int d;
    int base_d;
    int n = 0;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    set_default_regs();
    repeat (2) step();
    push_dump(regs);
    push_dump(regs);
    base_d = done_cnt;
    rst_n = 1'b1;
    r = cyc_cnt;
    wait_done(base_d, 400, 1'b0);
    checks++; if (rise_cyc - r != 100) begin errors++; $display("FAIL timer_first: got %0d, required 100", rise_cyc - r); end
    d = done_cyc;
    while (rise_cyc <= d && n < 300) begin
      step();
      n++;
    end
    checks++; if (rise_cyc - d != 100) begin errors++; $display("FAIL timer_next: got %0d, required 100", rise_cyc - d); end
    wait_done(base_d + 1, 200, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timer_sb: %0d left, required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef REG_DUMP_PERIODIC_EN
    test_periodic();
`else
    test_single_dump();
    test_random_ready();
    test_snapshot();
    test_reset_mid_dump();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
